// File: rtl/vga_pkg.sv
// Shared VGA geometry constants, pixel bundle and plot-arbiter state encoding.
package vga_pkg;
  localparam int X_W      = 8;
  localparam int Y_W      = 7;
  localparam int C_W      = 3;
  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
    logic [C_W-1:0] c;
  } pixel_t;
endpackage

// File: rtl/burst_counter.sv
// Counts accepts within one ownership tenure; saturates at MAX_BURST-1 and flags it.
module burst_counter #(
  parameter int MAX_BURST = 16
) (
  input  logic clock,
  input  logic resetb,
  input  logic clear,
  input  logic incr,
  output logic terminal
);
  // 8 bits covers the full legal MAX_BURST range (up to 255)
  localparam logic [7:0] LAST = 8'(MAX_BURST - 1);

  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear)                      cnt_d = '0;
    else if (incr && cnt_q != LAST) cnt_d = cnt_q + 8'd1;
  end

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign terminal = (cnt_q == LAST);
endmodule

// File: rtl/plot_arbiter.sv
// Two-requester pixel arbiter feeding a registered VGA plot port with burst-limited rotation.
// Optional out-of-range pixel suppression and sticky err enabled by PLOT_BOUNDS_CHECK_EN.
module plot_arbiter
  import vga_pkg::*;
#(
  parameter int MAX_BURST = 16
) (
  input  logic           clock,
  input  logic           resetb,
  input  logic           req0,
  input  logic [X_W-1:0] x0,
  input  logic [Y_W-1:0] y0,
  input  logic [C_W-1:0] colour0,
  output logic           gnt0,
  input  logic           req1,
  input  logic [X_W-1:0] x1,
  input  logic [Y_W-1:0] y1,
  input  logic [C_W-1:0] colour1,
  output logic           gnt1,
  output logic [X_W-1:0] vga_x,
  output logic [Y_W-1:0] vga_y,
  output logic [C_W-1:0] vga_colour,
  output logic           vga_plot,
  output logic           err
);
  arb_state_e state_q, state_d;
  logic       last_q, last_d;   // 1 = requester 1 owned last, so 0 wins the next tie
  logic       terminal, cnt_clr, cnt_inc, accept;
  pixel_t     acc_pix, pix_q, pix_d;
  logic       plot_q, plot_d;

  assign gnt0   = (state_q == ST_OWN0) & req0;
  assign gnt1   = (state_q == ST_OWN1) & req1;
  assign accept = gnt0 | gnt1;

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    cnt_clr = 1'b0;
    cnt_inc = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req0 && req1) state_d = last_q ? ST_OWN0 : ST_OWN1;
        else if (req0)    state_d = ST_OWN0;
        else if (req1)    state_d = ST_OWN1;
      end
      ST_OWN0: begin
        if (req0) begin
          if (terminal && req1) state_d = ST_OWN1;
        end else begin
          state_d = req1 ? ST_OWN1 : ST_IDLE;
        end
      end
      ST_OWN1: begin
        if (req1) begin
          if (terminal && req0) state_d = ST_OWN0;
        end else begin
          state_d = req0 ? ST_OWN0 : ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // a fresh tenure restarts the burst count even when the last pixel of the old one was accepted
    if (state_d != state_q && state_d != ST_IDLE) begin
      cnt_clr = 1'b1;
      last_d  = (state_d == ST_OWN1);
    end else if (accept) begin
      cnt_inc = 1'b1;
    end
  end

  burst_counter #(.MAX_BURST(MAX_BURST)) u_burst (
    .clock    (clock),
    .resetb   (resetb),
    .clear    (cnt_clr),
    .incr     (cnt_inc),
    .terminal (terminal)
  );

  always_comb begin
    acc_pix = gnt1 ? {x1, y1, colour1} : {x0, y0, colour0};
  end

`ifdef PLOT_BOUNDS_CHECK_EN
  localparam logic [X_W-1:0] X_MAX = X_W'(SCREEN_W - 1);
  localparam logic [Y_W-1:0] Y_MAX = Y_W'(SCREEN_H - 1);
  logic in_range, err_q, err_d;

  assign in_range = (acc_pix.x <= X_MAX) && (acc_pix.y <= Y_MAX);

  always_comb begin
    plot_d = accept & in_range;
    err_d  = err_q | (accept & ~in_range);
  end

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) err_q <= 1'b0;
    else         err_q <= err_d;
  end

  assign err = err_q;
`else
  always_comb begin
    plot_d = accept;
  end

  assign err = 1'b0;
`endif

  always_comb begin
    pix_d = plot_d ? acc_pix : pix_q;
  end

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      state_q <= ST_IDLE;
      last_q  <= 1'b1;
      plot_q  <= 1'b0;
      pix_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      plot_q  <= plot_d;
      pix_q   <= pix_d;
    end
  end

  assign vga_x      = pix_q.x;
  assign vga_y      = pix_q.y;
  assign vga_colour = pix_q.c;
  assign vga_plot   = plot_q;
endmodule

// File: tb/tb_plot_arbiter.sv
// Scoreboard bench for plot_arbiter: driver + tenure-level reference model, negedge monitor.
module tb_plot_arbiter;
  localparam int MB = 4;
  localparam int NEVER = 32'h7fffffff;

  logic clock = 1'b0;
  logic resetb = 1'b0;
  logic req0 = 1'b0, req1 = 1'b0;
  logic [7:0] x0 = '0, x1 = '0;
  logic [6:0] y0 = '0, y1 = '0;
  logic [2:0] colour0 = '0, colour1 = '0;
  logic gnt0, gnt1, vga_plot, err;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;

  plot_arbiter #(.MAX_BURST(MB)) dut (
    .clock(clock), .resetb(resetb),
    .req0(req0), .x0(x0), .y0(y0), .colour0(colour0), .gnt0(gnt0),
    .req1(req1), .x1(x1), .y1(y1), .colour1(colour1), .gnt1(gnt1),
    .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour),
    .vga_plot(vga_plot), .err(err)
  );

  always #5 clock = ~clock;

  typedef struct { int stamp; logic [7:0] x; logic [6:0] y; logic [2:0] c; } pix_t;
  typedef struct { int stamp; int g; } gnt_t;
  pix_t pq[$];
  gnt_t gq[$];

  int   cyc = 0;
  int   checks = 0, errors = 0;
  bit   in_rst = 1'b1;
  int   own = -1, run = 0, last = 1, last_g = -1, err_at = NEVER;
  logic [7:0] hx = '0;
  logic [6:0] hy = '0;
  logic [2:0] hc = '0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Reference: who owns the port, how many pixels it has taken this tenure, who owned last.
  task automatic model_step(input bit r0, input bit r1, output int g);
    bit r [2];
    int nxt;
    r[0] = r0; r[1] = r1;
    g = -1;
    nxt = own;
    if (own < 0) begin
      if (r0 && r1)  nxt = (last == 1) ? 0 : 1;
      else if (r0)   nxt = 0;
      else if (r1)   nxt = 1;
    end else if (r[own]) begin
      g = own;
      run++;
      if (run >= MB && r[1-own]) nxt = 1 - own;
    end else begin
      nxt = r[1-own] ? 1 - own : -1;
    end
    if (nxt >= 0 && nxt != own) begin run = 0; last = nxt; end
    own = nxt;
  endtask

  task automatic drive(input bit r0, input logic [7:0] ax0, input logic [6:0] ay0, input logic [2:0] ac0,
                       input bit r1, input logic [7:0] ax1, input logic [6:0] ay1, input logic [2:0] ac1);
    int g;
    pix_t p;
    @(posedge clock); #1;
    req0 = r0; x0 = ax0; y0 = ay0; colour0 = ac0;
    req1 = r1; x1 = ax1; y1 = ay1; colour1 = ac1;
    model_step(r0, r1, g);
    gq.push_back('{cyc, g});
    last_g = g;
    if (g >= 0) begin
      p.stamp = cyc + 1;
      p.x = (g == 1) ? ax1 : ax0;
      p.y = (g == 1) ? ay1 : ay0;
      p.c = (g == 1) ? ac1 : ac0;
`ifdef PLOT_BOUNDS_CHECK_EN
      if (p.x > 8'd159 || p.y > 7'd119) begin
        if (err_at == NEVER) err_at = cyc + 1;
      end else pq.push_back(p);
`else
      pq.push_back(p);
`endif
    end
  endtask

  // Pending data is held until granted; otherwise fresh random pixel.
  task automatic step(input bit w0, input bit w1);
    logic [7:0] nx0 = x0, nx1 = x1;
    logic [6:0] ny0 = y0, ny1 = y1;
    logic [2:0] nc0 = colour0, nc1 = colour1;
    if (!(req0 && last_g != 0 && w0)) begin
      nx0 = 8'($urandom_range(0, 170)); ny0 = 7'($urandom_range(0, 127)); nc0 = 3'($urandom);
    end
    if (!(req1 && last_g != 1 && w1)) begin
      nx1 = 8'($urandom_range(0, 170)); ny1 = 7'($urandom_range(0, 127)); nc1 = 3'($urandom);
    end
    drive(w0, nx0, ny0, nc0, w1, nx1, ny1, nc1);
  endtask

  task automatic do_reset();
    @(posedge clock); #2;
    resetb = 1'b0; in_rst = 1'b1;
    req0 = 1'b0; req1 = 1'b0;
    pq.delete(); gq.delete();
    own = -1; run = 0; last = 1; last_g = -1; err_at = NEVER;
    hx = '0; hy = '0; hc = '0;
    #1;
    chk("rst_immediate", {gnt0, gnt1, vga_plot, err, vga_x, vga_y, vga_colour}, 32'h0);
    repeat (2) @(posedge clock);
    #1;
    resetb = 1'b1; in_rst = 1'b0;
  endtask

  always @(negedge clock) begin
    gnt_t e;
    pix_t p;
    bit exp_plot;
    if (in_rst) begin
      chk("rst_outputs", {gnt0, gnt1, vga_plot, err, vga_x, vga_y, vga_colour}, 32'h0);
    end else begin
      if (gq.size() > 0 && gq[0].stamp == cyc) begin
        e = gq.pop_front();
        chk("gnt", {gnt0, gnt1}, (e.g == 0) ? 2'b10 : (e.g == 1) ? 2'b01 : 2'b00);
      end
      exp_plot = (pq.size() > 0 && pq[0].stamp == cyc);
      chk("vga_plot", vga_plot, exp_plot);
      if (exp_plot) begin
        p = pq.pop_front();
        if (vga_plot) begin
          chk("vga_pixel", {vga_x, vga_y, vga_colour}, {p.x, p.y, p.c});
          hx = p.x; hy = p.y; hc = p.c;
        end
      end else if (!vga_plot) begin
        chk("vga_hold", {vga_x, vga_y, vga_colour}, {hx, hy, hc});
      end
      chk("err", err, cyc >= err_at);
    end
  end

  initial begin
    do_reset();
    // lone requester 0: one IDLE cycle, grant, then pixel on VGA
    drive(1, 8'd5, 7'd7, 3'd3, 0, 8'd0, 7'd0, 3'd0);
    drive(1, 8'd5, 7'd7, 3'd3, 0, 8'd0, 7'd0, 3'd0);
    drive(0, 8'd5, 7'd7, 3'd3, 0, 8'd0, 7'd0, 3'd0);
    repeat (2) step(0, 0);

    // simultaneous requests from reset: 0 first, rotation every MB accepts
    do_reset();
    repeat (14) step(1, 1);
    repeat (2) step(0, 0);

    // requester 1 alone never rotates
    do_reset();
    repeat (40) step(0, 1);
    repeat (2) step(0, 0);

    // owner drops mid-burst while the other waits
    do_reset();
    repeat (3) step(1, 0);
    repeat (2) step(1, 1);
    repeat (4) step(0, 1);
    repeat (2) step(0, 0);

`ifdef PLOT_BOUNDS_CHECK_EN
    do_reset();
    drive(1, 8'd160, 7'd0, 3'd5, 0, 8'd0, 7'd0, 3'd0);
    drive(1, 8'd160, 7'd0, 3'd5, 0, 8'd0, 7'd0, 3'd0);
    drive(1, 8'd159, 7'd119, 3'd2, 0, 8'd0, 7'd0, 3'd0);
    repeat (3) step(0, 0);
`endif

    // reset in the middle of a burst, then the next tie goes to requester 0
    do_reset();
    repeat (3) step(1, 1);
    do_reset();
    repeat (6) step(1, 1);

    // random traffic with occasional drops of pending requests
    for (int i = 0; i < 2000; i++) begin
      bit w0, w1;
      w0 = (req0 && last_g != 0) ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 3) != 0);
      w1 = (req1 && last_g != 1) ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 3) != 0);
      step(w0, w1);
      if (i == 1000) do_reset();
    end
    repeat (3) step(0, 0);
    chk("pq_drained", pq.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
